predictor_bht_check: RTL
========================

Name: predictor_bht_check

Overview:
- Parametrised successor to the branch prediction checker. Adds a branch history table (BHT) of saturating counters that supplies taken/not-taken predictions at fetch.
- A FIFO of in-flight predictions holds each branch until its flags resolve.
- A registered check stage produces success, result, failback address and flush, and trains the table.
- Sits between fetch (predict side) and writeback/ALU flags (resolve side).

Parameters:
- ADDR_W, 11, width of PC and branch/jump addresses
- INDEX_W, 4, BHT index bits (2**INDEX_W entries), index = pred_pc[INDEX_W-1:0]
- CTR_W, 2, saturating counter width (min 2)
- DEPTH, 4, in-flight FIFO entries (power of 2)
- STAT_W, 16, mispredict counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pred_valid  in  1  fetch presents a branch
- pred_ready  out  1  FIFO not full
- pred_pc  in  ADDR_W  branch instruction PC
- pred_type  in  2  00 unconditional, 01 zero, 10 negative, 11 carry
- pred_branch_addr  in  ADDR_W  target if taken
- pred_jump_addr  in  ADDR_W  sequential/not-taken address
- pred_taken  out  1  combinational prediction for the current pred_pc/pred_type
- pred_next_addr  out  ADDR_W  pred_taken ? pred_branch_addr : pred_jump_addr
- res_valid  in  1  oldest in-flight branch resolves this cycle
- W_zero, W_negative, carry  in  1 each  resolved flags
- out_valid  out  1  registered, one-cycle pulse per accepted resolve
- prediction_success  out  1  registered
- branch_result  out  1  registered actual direction
- failback_addr  out  ADDR_W  registered corrective address
- flush  out  1  registered, = out_valid & ~prediction_success
- res_error  out  1  registered pulse: res_valid with FIFO empty
- mispredict_count  out  STAT_W  saturating count of mispredictions

Behaviour:
- Reset:
  - All BHT counters = 2**(CTR_W-1)-1 (weakly not-taken).
  - FIFO empty, pred_ready = 1.
  - out_valid, prediction_success, branch_result, flush, res_error = 0.
  - failback_addr = 0, mispredict_count = 0.
  - Reset mid-operation discards all in-flight entries.
- Prediction:
  - pred_taken = counter MSB for type 01/10/11, and 1 for type 00.
  - The read returns the registered table value; there is no bypass of a same-cycle update.
- Push:
  - Occurs when pred_valid & pred_ready.
  - Stores {predicted taken, index, type, branch_addr, jump_addr}.
  - pred_ready = ~full; it stays 0 when full even if a pop happens the same cycle.
- Resolve:
  - Applies only if res_valid & ~empty. It pops the head entry. Actual direction: type 00 = 1, 01 = W_zero, 10 = W_negative, 11 = carry.
  - Next edge:
    - out_valid = 1
    - branch_result = actual
    - prediction_success = (actual == predicted)
    - failback_addr = predicted ? jump_addr : branch_addr
    - flush = ~success
- Training:
  - On the same edge as the pop, types 01/10/11 increment the counter on actual = 1 and decrement on actual = 0.
  - Counters saturate at 0 and 2**CTR_W-1.
  - Type 00 never updates the table.
- Mispredict:
  - On the pop edge the whole FIFO is cleared (head and younger entries).
  - Any push in that cycle is discarded.
  - mispredict_count increments and saturates at all-ones.
- Underflow: res_valid with the FIFO empty produces no pop and no table change. out_valid = 0 and res_error = 1 on the next cycle.
- Simultaneous push and pop, no mispredict: both occur and occupancy is unchanged. Pointers wrap modulo DEPTH; a separate count of width log2(DEPTH)+1 distinguishes full from empty.
- Simultaneous predict and train of the same index: the prediction uses the old value, and the update is visible the next cycle.
- out_valid/flush/res_error are single-cycle pulses. failback_addr, prediction_success and branch_result hold their value until the next resolve.

Decomposition:
- Shared package predictor_pkg holds:
  - branch type constants BR_UNCOND=2'b00, BR_ZERO=2'b01, BR_NEG=2'b10, BR_CARRY=2'b11
  - the FIFO entry field layout/width
- One natural sub-module: predictor_inflight_fifo (parametrised DEPTH/width, push/pop/clear, full/empty). The BHT array, training and check stage stay in the top.

Test Plan:
- Reset, then push pc=0x005 type 01 -> pred_taken=0, pred_next_addr=jump_addr. Resolve with W_zero=1 -> next cycle out_valid=1, prediction_success=0, branch_result=1, failback_addr=branch_addr, flush=1, mispredict_count=1.
- Resolve the same pc type 01 taken three times, each as a separate push/resolve -> counter 1→2→3→3 (saturates). A fourth push gives pred_taken=1. A resolve with W_zero=1 gives prediction_success=1, flush=0, failback_addr=jump_addr.
- Fill DEPTH=4 entries -> pred_ready=0 and a fifth pred_valid is not accepted. Do a push and resolve together at full -> the push is refused. Next cycle, push+pop -> occupancy stays 3→3.
- Three entries in flight with a mispredicting head while a push is presented -> FIFO empty after the edge, the pushed entry is discarded, and the next res_valid gives res_error=1.
- Type 00 with branch_addr=0x123 -> pred_taken=1; resolve -> success=1, branch_result=1, table unchanged (a type-01 predict at the same index still gives 0).
- Assert reset with 2 entries in flight and trained counters -> all counters return to 01, the FIFO is empty, outputs are 0, and mispredict_count=0.

Source files
------------

// File: rtl/predictor_pkg.sv
// Shared definitions for the BHT branch predictor checker: branch types,
// in-flight entry layout and the branch-direction resolve rule.
package predictor_pkg;

  localparam logic [1:0] BR_UNCOND = 2'b00;
  localparam logic [1:0] BR_ZERO   = 2'b01;
  localparam logic [1:0] BR_NEG    = 2'b10;
  localparam logic [1:0] BR_CARRY  = 2'b11;

  localparam int unsigned TYPE_W = 2;

  // In-flight entry, MSB to LSB: {taken, index, type, branch_addr, jump_addr}
  function automatic int unsigned entry_w(int unsigned addr_w, int unsigned index_w);
    return 1 + index_w + TYPE_W + 2 * addr_w;
  endfunction

  function automatic logic resolve_dir(logic [1:0] br_type, logic w_zero,
                                       logic w_negative, logic w_carry);
    logic dir;
    case (br_type)
      BR_ZERO:  dir = w_zero;
      BR_NEG:   dir = w_negative;
      BR_CARRY: dir = w_carry;
      default:  dir = 1'b1;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/predictor_inflight_fifo.sv
// FIFO of in-flight predictions; clear empties it and wins over push/pop.
module predictor_inflight_fifo
  import predictor_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; contents are only read while non-empty
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/predictor_bht_check.sv
// Branch predictor with a BHT of saturating counters, an in-flight FIFO and a
// registered check stage that reports mispredictions and trains the table.
module predictor_bht_check
  import predictor_pkg::*;
#(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [ADDR_W-1:0] pred_pc,
  input  logic [1:0]        pred_type,
  input  logic [ADDR_W-1:0] pred_branch_addr,
  input  logic [ADDR_W-1:0] pred_jump_addr,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_addr,
  input  logic              res_valid,
  input  logic              W_zero,
  input  logic              W_negative,
  input  logic              carry,
  output logic              out_valid,
  output logic              prediction_success,
  output logic              branch_result,
  output logic [ADDR_W-1:0] failback_addr,
  output logic              flush,
  output logic              res_error,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int unsigned ENTRIES = 2 ** INDEX_W;
  localparam int unsigned ENTRY_W = entry_w(ADDR_W, INDEX_W);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0]   bht_q [ENTRIES];
  logic [INDEX_W-1:0] pred_idx;
  logic               fifo_full, fifo_empty, push, pop, actual, mispredict;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic               h_taken;
  logic [INDEX_W-1:0] h_idx;
  logic [1:0]         h_type;
  logic [ADDR_W-1:0]  h_baddr, h_jaddr;
  logic [CTR_W-1:0]   ctr_cur, ctr_d;
  logic               out_valid_q, success_q, result_q, flush_q, err_q;
  logic [ADDR_W-1:0]  failback_q;
  logic [STAT_W-1:0]  miscnt_q;

  // Prediction reads the registered table only
  assign pred_idx       = pred_pc[INDEX_W-1:0];
  assign pred_taken     = (pred_type == BR_UNCOND) ? 1'b1 : bht_q[pred_idx][CTR_W-1];
  assign pred_next_addr = pred_taken ? pred_branch_addr : pred_jump_addr;
  assign pred_ready     = ~fifo_full;

  assign push       = pred_valid & ~fifo_full;
  assign pop        = res_valid & ~fifo_empty;
  assign push_entry = {pred_taken, pred_idx, pred_type, pred_branch_addr, pred_jump_addr};
  assign {h_taken, h_idx, h_type, h_baddr, h_jaddr} = head_entry;
  assign actual     = resolve_dir(h_type, W_zero, W_negative, carry);
  assign mispredict = pop & (actual != h_taken);

  predictor_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (mispredict),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Saturating step of the head entry's counter
  always_comb begin
    ctr_cur = bht_q[h_idx];
    ctr_d   = ctr_cur;
    if (actual) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= CTR_INIT;
    end else if (pop && (h_type != BR_UNCOND)) begin
      bht_q[h_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      success_q   <= 1'b0;
      result_q    <= 1'b0;
      failback_q  <= '0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      miscnt_q    <= '0;
    end else begin
      out_valid_q <= pop;
      flush_q     <= mispredict;
      err_q       <= res_valid & fifo_empty;
      if (pop) begin
        success_q  <= (actual == h_taken);
        result_q   <= actual;
        failback_q <= h_taken ? h_jaddr : h_baddr;
      end
      if (mispredict && (miscnt_q != '1)) miscnt_q <= miscnt_q + 1'b1;
    end
  end

  assign out_valid          = out_valid_q;
  assign prediction_success = success_q;
  assign branch_result      = result_q;
  assign failback_addr      = failback_q;
  assign flush              = flush_q;
  assign res_error          = err_q;
  assign mispredict_count   = miscnt_q;

endmodule
